// File: rtl/i2s_pkg.sv
// Shared frame geometry and slot type for the I2S receive path.
package i2s_pkg;

  localparam int FRAME_SLOTS     = 64;
  localparam int HALF_SLOTS      = 32;
  localparam int SLOT_W          = 6;
  localparam int FIRST_DATA_SLOT = 1;

  typedef logic [SLOT_W-1:0] slot_t;

  // Slot that must follow s; 63 wraps to 0.
  function automatic slot_t next_slot(input slot_t s);
    return slot_t'((int'(s) + 1) % FRAME_SLOTS);
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Stereo pair output channel: receiver drives data/valid, consumer drives ready.
interface i2s_rx_if #(
  parameter int WIDTH = 24
);

  logic [WIDTH-1:0] data_l;
  logic [WIDTH-1:0] data_r;
  logic             valid;
  logic             ready;

  modport master (output data_l, output data_r, output valid, input ready);
  modport slave  (input data_l, input data_r, input valid, output ready);

endinterface

// File: rtl/i2s_sync.sv
// Two-flop synchroniser for sd plus one-ck sck rise strobe; sck_d resets high so
// a bit clock already high at reset release does not look like a rising edge.
module i2s_sync (
  input  logic ck,
  input  logic rst,
  input  logic sck,
  input  logic sd,
  output logic sd_s,
  output logic rise
);

  logic sd_meta_q, sd_meta_d;
  logic sd_s_q, sd_s_d;
  logic sck_d_q, sck_d_d;

  always_comb begin
    sd_meta_d = sd;
    sd_s_d    = sd_meta_q;
    sck_d_d   = sck;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      sd_meta_q <= 1'b0;
      sd_s_q    <= 1'b0;
      sck_d_q   <= 1'b1;
    end else begin
      sd_meta_q <= sd_meta_d;
      sd_s_q    <= sd_s_d;
      sck_d_q   <= sck_d_d;
    end
  end

  assign sd_s = sd_s_q;
  assign rise = sck & ~sck_d_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: stereo pair valid on the ck edge of the slot 32+WIDTH sck rise; an
// unaccepted pair is overwritten and flags sticky overrun. Slot checking: I2S_RX_FRAME_CHECK_EN.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic     ck,
  input  logic     rst,
  input  logic     sck,
  input  slot_t    frame_posn,
  input  logic     sd,
  i2s_rx_if.master out_if,
  output logic     overrun,
  output logic     frame_err
);

  localparam logic [4:0] FIRST_SLOT = 5'(FIRST_DATA_SLOT);
  localparam logic [4:0] LAST_SLOT  = 5'(WIDTH);

  logic sd_s;
  logic rise;

  i2s_sync u_sync (
    .ck   (ck),
    .rst  (rst),
    .sck  (sck),
    .sd   (sd),
    .sd_s (sd_s),
    .rise (rise)
  );

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] left_hold_q, left_hold_d;
  logic [WIDTH-1:0] data_l_q, data_l_d;
  logic [WIDTH-1:0] data_r_q, data_r_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             left_ok_q, left_ok_d;

  logic [4:0]       slot;
  logic             chan;
  logic [WIDTH-1:0] word;

  assign slot = frame_posn[4:0];
  assign chan = (frame_posn >= slot_t'(HALF_SLOTS));
  assign word = WIDTH'({shreg_q, sd_s});

  always_comb begin
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    data_l_d    = data_l_q;
    data_r_d    = data_r_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    left_ok_d   = left_ok_q;

    if (valid_q && out_if.ready) valid_d = 1'b0;

    if (rise && (slot >= FIRST_SLOT) && (slot <= LAST_SLOT)) shreg_d = word;

    if (rise && (slot == LAST_SLOT)) begin
      if (!chan) begin
        left_hold_d = word;
        left_ok_d   = 1'b1;
      end else if (left_ok_q) begin
        // A right word only forms a pair if its left half was seen since reset.
        data_l_d  = left_hold_q;
        data_r_d  = word;
        valid_d   = 1'b1;
        left_ok_d = 1'b0;
        if (valid_q && !out_if.ready) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      shreg_q     <= '0;
      left_hold_q <= '0;
      data_l_q    <= '0;
      data_r_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      left_ok_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      data_l_q    <= data_l_d;
      data_r_q    <= data_r_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      left_ok_q   <= left_ok_d;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  slot_t last_posn_q, last_posn_d;
  logic  posn_seen_q, posn_seen_d;
  logic  frame_err_q, frame_err_d;

  // The first rise after reset only primes last_posn.
  always_comb begin
    last_posn_d = last_posn_q;
    posn_seen_d = posn_seen_q;
    frame_err_d = frame_err_q;
    if (rise) begin
      if (posn_seen_q && (frame_posn != next_slot(last_posn_q))) frame_err_d = 1'b1;
      last_posn_d = frame_posn;
      posn_seen_d = 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      last_posn_q <= '0;
      posn_seen_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      last_posn_q <= last_posn_d;
      posn_seen_q <= posn_seen_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign out_if.data_l = data_l_q;
  assign out_if.data_r = data_r_q;
  assign out_if.valid  = valid_q;
  assign overrun       = overrun_q;

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Serial-to-parallel I2S receiver for the MEMS microphone path.
- Sits directly downstream of the I2S clock generator and consumes its registered sck, ws-aligned frame_posn, and the mic serial data line.
- Assembles left/right PCM words per 64-slot frame.
- Presents each coherent stereo pair to the next stage through a valid/ready handshake.

Parameters:
- WIDTH, 24, sample bits per channel; legal range 1..31.

Ports:
- ck  input  1  system clock (12MHz)
- rst  input  1  synchronous active-high reset
- sck  input  1  I2S bit clock, registered in ck domain
- frame_posn  input  6  slot counter 0..63; 0..31 left, 32..63 right
- sd  input  1  mic serial data, asynchronous to ck
- data_l  output  WIDTH  left sample, two's complement, MSB first on wire
- data_r  output  WIDTH  right sample
- valid  output  1  data_l/data_r hold an unconsumed pair
- ready  input  1  consumer accepts pair when valid && ready
- overrun  output  1  sticky: a pair was overwritten before acceptance
- frame_err  output  1  sticky slot-sequence error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, ck; reset is synchronous and active-high (rst).
- sd synchroniser: sd passes through a 2-flop synchroniser (sd_s) in the ck domain.
- Bit-clock edge detect: sck_d is sck delayed one ck. rise = sck && !sck_d, one ck wide.
- Reset values:
  - sck_d resets to 1, so no spurious rise if sck is high at reset release.
  - Shift register, left holding register, data_l, data_r, valid, overrun, frame_err and left_ok all reset to 0.
- Slot decode on rise: slot = frame_posn[4:0]; chan = frame_posn[5].
  - Data occupies slots 1..WIDTH (one-bit I2S delay after WS change).
  - Slots 0 and WIDTH+1..31 are ignored; shreg is unchanged there.
- Capture on rise with slot in 1..WIDTH: shreg <= {shreg[WIDTH-2:0], sd_s}.
- Word completion on rise with slot == WIDTH; word = {shreg[WIDTH-2:0], sd_s}.
  - chan==0: left holding register <= word; left_ok <= 1.
  - chan==1 and left_ok: data_l <= left holding register; data_r <= word; valid <= 1; left_ok <= 0. Outputs update on that same ck edge.
  - chan==1 and !left_ok: word discarded; no valid. This covers reset mid-frame and the first right half after reset.
- Handshake:
  - Accept on valid && ready at a ck edge → valid <= 0, unless a new pair loads on that same edge.
  - Accept and new pair on the same edge → new pair loads, valid stays 1, no overrun.
  - valid && !ready when a new pair loads → pair overwritten, valid stays 1, overrun <= 1 (sticky until rst).
  - data_l/data_r are stable whenever valid is high, except on overwrite.
- Latency: valid rises on the ck edge of the sck rise in slot 32+WIDTH, i.e. 3 ck after sd is stable at the pin (2 sync + 1).
- rst asserted mid-operation wins over every other update in that cycle.

Optional Feature:
- Macro: I2S_RX_FRAME_CHECK_EN.
- Defined:
  - On each rise, frame_posn must equal (last_posn+1) mod 64. 63→0 wrap is legal.
  - Mismatch → frame_err <= 1 (sticky until rst).
  - The first rise after rst only loads last_posn and is not checked.
- Undefined: no last_posn logic; frame_err tied 0.

Decomposition:
- Package i2s_pkg:
  - FRAME_SLOTS=64, HALF_SLOTS=32, SLOT_W=6.
  - FIRST_DATA_SLOT=1.
  - typedef slot_t (6-bit).
- Sub-module i2s_sync: 2-flop sd synchroniser plus sck rise detector with reset-to-1 sck_d. Outputs sd_s and rise.

Test Plan:
- WIDTH=24; mic model drives left 0xA5A5A5, right 0x123456 MSB-first in slots 1..24 / 33..56, changing on sck fall; ready=1 → one-ck valid pulse at slot-56 rise; data_l=0xA5A5A5, data_r=0x123456; overrun=0.
- sd=1 in slots 0 and 25..31 and 57..63, data 0x000001 both channels → data_l=data_r=0x000001; ignored slots have no effect.
- ready=0 across two frames (0x111111/0x222222 then 0x333333/0x444444) → valid held, overrun=1 after second frame, data_l=0x333333, data_r=0x444444; ready=1 then clears valid; overrun stays 1.
- rst pulsed at frame_posn=40 → all outputs 0 next edge; right word of that frame discarded; first valid arrives at slot 56 of the next full frame.
- With sck already high at rst release → no capture before the next genuine sck rise.
- I2S_RX_FRAME_CHECK_EN defined: frame_posn jumps 10→12 → frame_err=1 and sticky. Normal 63→0 wrap → frame_err stays 0.
